// File: rtl/dadda_mac6x6_acc.sv
// Pipelined 6x6 multiply-accumulate stage.
// Operand pairs land in S1, feed a combinational Dadda multiplier, and are summed
// N_TERMS at a time into a saturating dot product presented on a valid/ready output.

module dadda_mul6x6 (
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic [11:0] p
);
    logic [7:0]  col [16];
    logic [7:0]  nxt [16];
    int          h   [16];
    int          nh  [16];
    int          pos;
    int          tgt;
    logic        x, y, z;
    logic [11:0] row0, row1;

    // Column-wise Dadda reduction 6 -> 4 -> 3 -> 2 rows, then a single carry-propagate add
    always_comb begin
        for (int c = 0; c < 16; c++) begin
            col[4'(c)] = '0;
            nxt[4'(c)] = '0;
            h[4'(c)]   = 0;
            nh[4'(c)]  = 0;
        end
        pos  = 0;
        tgt  = 0;
        x    = 1'b0;
        y    = 1'b0;
        z    = 1'b0;
        row0 = '0;
        row1 = '0;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                col[4'(i + j)][3'(h[4'(i + j)])] = a[3'(i)] & b[3'(j)];
                h[4'(i + j)] = h[4'(i + j)] + 1;
            end
        end

        for (int s = 0; s < 3; s++) begin
            tgt = 4 - s;
            for (int c = 0; c < 16; c++) begin
                nxt[4'(c)] = '0;
                nh[4'(c)]  = 0;
            end
            // column 12 only ever receives carries that are zero for a 12-bit product
            for (int c = 0; c < 12; c++) begin
                pos = 0;
                for (int k = 0; k < 4; k++) begin
                    if (nh[4'(c)] + h[4'(c)] - pos > tgt) begin
                        x = col[4'(c)][3'(pos)];
                        y = col[4'(c)][3'(pos + 1)];
                        if (nh[4'(c)] + h[4'(c)] - pos == tgt + 1) begin
                            nxt[4'(c)][3'(nh[4'(c)])] = x ^ y;
                            nxt[4'(c + 1)][3'(nh[4'(c + 1)])] = x & y;
                            pos = pos + 2;
                        end else begin
                            z = col[4'(c)][3'(pos + 2)];
                            nxt[4'(c)][3'(nh[4'(c)])] = x ^ y ^ z;
                            nxt[4'(c + 1)][3'(nh[4'(c + 1)])] = (x & y) | (z & (x ^ y));
                            pos = pos + 3;
                        end
                        nh[4'(c)]     = nh[4'(c)] + 1;
                        nh[4'(c + 1)] = nh[4'(c + 1)] + 1;
                    end
                end
                for (int k = 0; k < 8; k++) begin
                    if (pos < h[4'(c)]) begin
                        nxt[4'(c)][3'(nh[4'(c)])] = col[4'(c)][3'(pos)];
                        nh[4'(c)] = nh[4'(c)] + 1;
                        pos = pos + 1;
                    end
                end
            end
            for (int c = 0; c < 16; c++) begin
                col[4'(c)] = nxt[4'(c)];
                h[4'(c)]   = nh[4'(c)];
            end
        end

        for (int c = 0; c < 12; c++) begin
            row0[4'(c)] = col[4'(c)][0];
            row1[4'(c)] = col[4'(c)][1];
        end
    end

    assign p = row0 + row1;
endmodule

module dadda_mac6x6_acc #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_a,
    input  logic [5:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    localparam int               CNT_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic {ST_EMPTY, ST_FULL} out_state_t;

    out_state_t       state, state_nxt;
    logic             s1_valid;
    logic [5:0]       s1_a, s1_b;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic [CNT_W-1:0] cnt;
    logic [11:0]      prod;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_sat;
    logic             sum_ovf;
    logic             last, s1_adv, adv, last_adv, accept;

    dadda_mul6x6 u_mul (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    // A last term may only leave S1 if the output register can take it
    assign last     = (cnt == LAST_CNT);
    assign s1_adv   = s1_valid & ~(last & out_valid & ~out_ready);
    assign in_ready = clr | ~s1_valid | s1_adv;
    // clr drops both the operand on offer and whatever S1 would have retired
    assign accept   = in_valid & in_ready & ~clr;
    assign adv      = s1_adv & ~clr;
    assign last_adv = adv & last;

    assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign sum_ovf = sum_ext[ACC_W];
    assign sum_sat = sum_ovf ? '1 : sum_ext[ACC_W-1:0];

    // S1 operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Accumulator, sticky overflow and term counter for the vector in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
        end else if (clr) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
        end else if (adv) begin
            if (last) begin
                acc     <= '0;
                ovf_acc <= 1'b0;
                cnt     <= '0;
            end else begin
                acc     <= sum_sat;
                ovf_acc <= ovf_acc | sum_ovf;
                cnt     <= cnt + 1'b1;
            end
        end
    end

    // Result data, loaded only when a vector completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (last_adv) begin
            out_sum <= sum_sat;
            out_ovf <= ovf_acc | sum_ovf;
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Output FSM next state; a reload while FULL keeps results back-to-back
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (last_adv) state_nxt = ST_FULL;
            ST_FULL:  if (!last_adv && out_ready) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Output FSM outputs
    always_comb begin
        out_valid = (state == ST_FULL);
    end
endmodule

// File: tb/tb_dadda_mac6x6_acc.sv
// Directed bench for dadda_mac6x6_acc: default, ACC_W=14 and N_TERMS=1 instances.
module tb_dadda_mac6x6_acc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr_s [3];
    logic        iv    [3];
    logic        ir    [3];
    logic        ov    [3];
    logic        ordy  [3];
    logic        of    [3];
    logic [5:0]  ia    [3];
    logic [5:0]  ib    [3];
    logic [15:0] sum0, sum2;
    logic [13:0] sum1;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_on   = 1'b0;
    bit done    = 1'b0;
    int exp_q[$];

    dadda_mac6x6_acc u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr_s[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[0]), .in_b(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_sum(sum0), .out_ovf(of[0]));

    dadda_mac6x6_acc #(.N_TERMS(8), .ACC_W(14)) u_d14 (
        .clk(clk), .rst_n(rst_n), .clr(clr_s[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[1]), .in_b(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_sum(sum1), .out_ovf(of[1]));

    dadda_mac6x6_acc #(.N_TERMS(1), .ACC_W(16)) u_n1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_s[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(ia[2]), .in_b(ib[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_sum(sum2), .out_ovf(of[2]));

    typedef struct packed {
        logic [7:0][5:0] a;
        logic [7:0][5:0] b;
        logic [15:0]     sum;
        logic            ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int sum_of(input int d);
        case (d)
            0:       return int'(sum0);
            1:       return int'(sum1);
            default: return int'(sum2);
        endcase
    endfunction

    // Offer one pair at posedge+1, returns at posedge+1 after the accepting edge
    task automatic push(input int d, input int a, input int b);
        bit got;
        int n;
        iv[d] = 1'b1;
        ia[d] = 6'(a);
        ib[d] = 6'(b);
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = ir[d];
            @(posedge clk);
            #1;
            n++;
        end
        iv[d] = 1'b0;
        if (!got) check("push_timeout", 0, 1);
        else if (d == 2 && sb_on) exp_q.push_back(a * b);
    endtask

    task automatic wait_result(input int d, output int s, output int o);
        int n;
        n = 0;
        while (!ov[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ov[d]) check("result_timeout", 0, 1);
        s = sum_of(d);
        o = int'(of[d]);
    endtask

    // Scoreboard for the N_TERMS=1 instance: each output handshake pops one product
    always @(negedge clk) begin
        if (sb_on && ov[2] && ordy[2]) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else begin
                check("sb_product", int'(sum2), exp_q.pop_front());
                check("sb_ovf", int'(of[2]), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, o;
        for (int d = 0; d < 3; d++) begin
            clr_s[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b0; ia[d] = '0; ib[d] = '0;
        end
        rst_n = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tbl[0].a[i] = 6'(i + 1); tbl[0].b[i] = 6'(i + 1);
            tbl[1].a[i] = 6'd63;     tbl[1].b[i] = 6'd63;
            tbl[2].a[i] = 6'd0;      tbl[2].b[i] = 6'(i);
            tbl[3].a[i] = 6'(i);     tbl[3].b[i] = 6'(63 - i);
            tbl[4].a[i] = 6'd63;     tbl[4].b[i] = 6'(i + 1);
            tbl[5].a[i] = 6'(1 << (i % 6)); tbl[5].b[i] = 6'd63;
        end
        tbl[0].sum = 16'd204;   tbl[0].ovf = 1'b0;
        tbl[1].sum = 16'd31752; tbl[1].ovf = 1'b0;
        tbl[2].sum = 16'd0;     tbl[2].ovf = 1'b0;
        tbl[3].sum = 16'd1624;  tbl[3].ovf = 1'b0;
        tbl[4].sum = 16'd2268;  tbl[4].ovf = 1'b0;
        tbl[5].sum = 16'd4158;  tbl[5].ovf = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(ov[0]), 0);
        check("rst_out_sum", int'(sum0), 0);
        check("rst_out_ovf", int'(of[0]), 0);
        check("rst_in_ready", int'(ir[0]), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ramp vector, one-cycle latency and a single-cycle valid
        ordy[0] = 1'b1;
        for (int i = 0; i < 8; i++) push(0, i + 1, 2);
        check("t1_not_early", int'(ov[0]), 0);
        @(posedge clk); #1;
        check("t1_valid", int'(ov[0]), 1);
        check("t1_sum", int'(sum0), 72);
        check("t1_ovf", int'(of[0]), 0);
        @(posedge clk); #1;
        check("t1_valid_one_cycle", int'(ov[0]), 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) push(0, int'(tbl[v].a[i]), int'(tbl[v].b[i]));
            wait_result(0, s, o);
            check($sformatf("tbl%0d_sum", v), s, int'(tbl[v].sum));
            check($sformatf("tbl%0d_ovf", v), o, int'(tbl[v].ovf));
        end

        // 2: saturation at ACC_W=14, then a clean vector
        ordy[1] = 1'b1;
        for (int i = 0; i < 8; i++) push(1, 63, 63);
        wait_result(1, s, o);
        check("t2_sat_sum", s, 16383);
        check("t2_sat_ovf", o, 1);
        for (int i = 0; i < 8; i++) push(1, i + 1, 2);
        wait_result(1, s, o);
        check("t2_next_sum", s, 72);
        check("t2_next_ovf", o, 0);

        // 3: backpressure with a pending result while a second vector streams in
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        for (int i = 0; i < 8; i++) push(0, i + 1, 2);
        @(posedge clk); #1;
        check("t3_first_valid", int'(ov[0]), 1);
        for (int i = 0; i < 8; i++) push(0, 63, 1);
        check("t3_in_ready_low", int'(ir[0]), 0);
        check("t3_held_sum", int'(sum0), 72);
        repeat (3) @(posedge clk);
        #1;
        check("t3_stable_sum", int'(sum0), 72);
        check("t3_stable_valid", int'(ov[0]), 1);
        check("t3_still_stalled", int'(ir[0]), 0);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("t3_second_valid", int'(ov[0]), 1);
        check("t3_second_sum", int'(sum0), 504);
        @(posedge clk); #1;
        check("t3_drained", int'(ov[0]), 0);

        // 4: clr discards a partial vector and the operand offered with it
        for (int i = 0; i < 3; i++) push(0, 5, 5);
        clr_s[0] = 1'b1;
        iv[0] = 1'b1; ia[0] = 6'd63; ib[0] = 6'd63;
        check("t4_ready_in_clr", int'(ir[0]), 1);
        @(posedge clk); #1;
        clr_s[0] = 1'b0;
        iv[0] = 1'b0;
        check("t4_no_result", int'(ov[0]), 0);
        for (int i = 0; i < 8; i++) push(0, 1, 1);
        wait_result(0, s, o);
        check("t4_sum", s, 8);
        check("t4_ovf", o, 0);

        // 5: asynchronous reset mid-vector with a result pending
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        for (int i = 0; i < 8; i++) push(0, 1, 1);
        wait_result(0, s, o);
        check("t5_pending_sum", s, 8);
        for (int i = 0; i < 3; i++) push(0, 2, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", int'(ov[0]), 0);
        check("t5_async_sum", int'(sum0), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 8; i++) push(0, 2, 3);
        wait_result(0, s, o);
        check("t5_after_sum", s, 48);
        check("t5_after_ovf", o, 0);

        // 6: N_TERMS=1 behaves as a pipelined multiplier
        ordy[2] = 1'b1;
        push(2, 7, 9);
        check("t6_not_early", int'(ov[2]), 0);
        push(2, 63, 1);
        check("t6_first_valid", int'(ov[2]), 1);
        check("t6_first_sum", int'(sum2), 63);
        @(posedge clk); #1;
        check("t6_second_valid", int'(ov[2]), 1);
        check("t6_second_sum", int'(sum2), 63);
        @(posedge clk); #1;
        check("t6_drained", int'(ov[2]), 0);

        // Every 6x6 product through the N_TERMS=1 instance under random out_ready
        sb_on = 1'b1;
        done  = 1'b0;
        fork
            begin
                for (int a = 0; a < 64; a++) begin
                    for (int b = 0; b < 64; b++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk); #1;
                        end
                        push(2, a, b);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ordy[2] = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        ordy[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        sb_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
